// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter. It sends a start bit, then DATA_WIDTH data bits LSB
// first, then an optional parity bit and STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT cycles.
module uart_tx_cfg #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  uart_tx_done
);
   localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned   BW        = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic          STOP_LAST = (STOP_BITS > 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state;
   logic [CW-1:0]         clk_cnt;
   logic [BW-1:0]         bit_idx;
   logic                  stop_idx;
   logic [DATA_WIDTH-1:0] data_sh;
   logic                  par_en_l;
   logic                  par_bit;
   logic                  bit_end;
   logic                  frame_end;
   logic                  accept;

   always_comb begin
      bit_end   = (clk_cnt == CNT_LAST);
      frame_end = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
      accept    = data_valid && ((state == IDLE) || frame_end);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         tx_out       <= 1'b1;
         busy         <= 1'b0;
         uart_tx_done <= 1'b0;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         stop_idx     <= 1'b0;
         data_sh      <= '0;
         par_en_l     <= 1'b0;
         par_bit      <= 1'b0;
      end else begin
         uart_tx_done <= frame_end;
         if (accept) begin
            // A request in the last stop cycle goes straight into the next start bit.
            state    <= START;
            tx_out   <= 1'b0;
            busy     <= 1'b1;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            data_sh  <= p_data;
            par_en_l <= par_en;
            par_bit  <= (^p_data) ^ par_typ;
         end else if (state != IDLE) begin
            if (!bit_end) begin
               clk_cnt <= clk_cnt + 1'b1;
            end else begin
               clk_cnt <= '0;
               case (state)
                  START: begin
                     state  <= DATA;
                     tx_out <= data_sh[0];
                  end
                  DATA: begin
                     if (bit_idx == BIT_LAST) begin
                        if (par_en_l) begin
                           state  <= PARITY;
                           tx_out <= par_bit;
                        end else begin
                           state  <= STOP;
                           tx_out <= 1'b1;
                        end
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                        data_sh <= data_sh >> 1;
                        tx_out  <= data_sh[1];
                     end
                  end
                  PARITY: begin
                     state  <= STOP;
                     tx_out <= 1'b1;
                  end
                  STOP: begin
                     if (frame_end) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        tx_out <= 1'b1;
                     end else begin
                        stop_idx <= 1'b1;
                     end
                  end
                  default: begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     tx_out <= 1'b1;
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg. It runs two configurations, (8,1,1) and (8,4,2), on shared stimulus.
// A frame-level line model is checked against both DUTs every cycle.
module tb_uart_tx_cfg;
   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic [7:0] p_data     = '0;
   logic       data_valid = 1'b0;
   logic       par_en     = 1'b0;
   logic       par_typ    = 1'b0;
   logic       tx0, busy0, done0, tx1, busy1, done1;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] cap_tx, cap_busy, cap_done;
   int          low_run, high_run, busy_len, done_at;

   uart_tx_cfg dut0 (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .par_en(par_en), .par_typ(par_typ),
      .tx_out(tx0), .busy(busy0), .uart_tx_done(done0)
   );

   uart_tx_cfg #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .par_en(par_en), .par_typ(par_typ),
      .tx_out(tx1), .busy(busy1), .uart_tx_done(done1)
   );

   always #5 clk = ~clk;

   // The line model holds each frame as a per-cycle bit vector, plus the current position in it.
   int          clks  [2] = '{1, 4};
   int          stops [2] = '{1, 2};
   int          m_len [2] = '{0, 0};
   int          m_pos [2] = '{0, 0};
   logic        m_done[2] = '{1'b0, 1'b0};
   logic [63:0] m_seq [2];

   function automatic logic [63:0] frame_vec(input logic [7:0] d, input logic pe,
                                             input logic pt, input int c);
      logic [63:0] v;
      int k;
      v = '1;
      k = 0;
      for (int r = 0; r < c; r++) begin v[k] = 1'b0; k++; end
      for (int b = 0; b < 8; b++)
         for (int r = 0; r < c; r++) begin v[k] = d[b]; k++; end
      if (pe)
         for (int r = 0; r < c; r++) begin v[k] = (^d) ^ pt; k++; end
      return v;
   endfunction

   function automatic logic exp_tx(input int k);
      return (m_len[k] != 0) ? m_seq[k][m_pos[k]] : 1'b1;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
         logic last;
         if (rst) begin
            m_len[k]  = 0;
            m_pos[k]  = 0;
            m_done[k] = 1'b0;
         end else begin
            last = (m_len[k] != 0) && (m_pos[k] == m_len[k] - 1);
            if (m_len[k] != 0) m_pos[k]++;
            if (last) m_len[k] = 0;
            m_done[k] = last;
            if (data_valid && m_len[k] == 0) begin
               m_seq[k] = frame_vec(p_data, par_en, par_typ, clks[k]);
               m_len[k] = (9 + int'(par_en) + stops[k]) * clks[k];
               m_pos[k] = 0;
            end
         end
      end
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      check_bit("model_tx0",   tx0,   exp_tx(0));
      check_bit("model_busy0", busy0, m_len[0] != 0);
      check_bit("model_done0", done0, m_done[0]);
      check_bit("model_tx1",   tx1,   exp_tx(1));
      check_bit("model_busy1", busy1, m_len[1] != 0);
      check_bit("model_done1", done1, m_done[1]);
   end

   task automatic send(input logic [7:0] d, input logic pe, input logic pt);
      @(negedge clk);
      p_data     = d;
      par_en     = pe;
      par_typ    = pt;
      data_valid = 1'b1;
   endtask

   // Sample i is the i-th cycle after the acceptance edge; sample 0 shows the start bit.
   task automatic capture0(input int n, input bit drop);
      cap_tx   = '0;
      cap_busy = '0;
      cap_done = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cap_tx[i]   = tx0;
         cap_busy[i] = busy0;
         cap_done[i] = done0;
         if (drop && i == 0) data_valid = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_bit("reset_tx0",   tx0,   1'b1);
      check_bit("reset_busy0", busy0, 1'b0);
      check_bit("reset_done0", done0, 1'b0);
      check_bit("reset_tx1",   tx1,   1'b1);
      rst = 1'b0;

      send(8'hA5, 1'b0, 1'b0);
      capture0(12, 1'b1);
      check_val("a5_line", 32'(cap_tx[10:0]),   32'h74A);
      check_val("a5_busy", 32'(cap_busy[11:0]), 32'h3FF);
      check_val("a5_done", 32'(cap_done[11:0]), 32'h400);

      send(8'h07, 1'b1, 1'b0);
      capture0(13, 1'b1);
      check_val("par_even_data", 32'(cap_tx[8:1]), 32'h07);
      check_bit("par_even_bit",  cap_tx[9],  1'b1);
      check_bit("par_even_stop", cap_tx[10], 1'b1);
      check_val("par_busy", 32'(cap_busy[12:0]), 32'h07FF);
      check_val("par_done", 32'(cap_done[12:0]), 32'h0800);

      send(8'h07, 1'b1, 1'b1);
      capture0(13, 1'b1);
      check_bit("par_odd_bit",  cap_tx[9],  1'b0);
      check_bit("par_odd_stop", cap_tx[10], 1'b1);
      check_val("par_odd_done", 32'(cap_done[12:0]), 32'h0800);

      repeat (60) @(negedge clk);
      send(8'h00, 1'b0, 1'b0);
      low_run  = 0;
      high_run = 0;
      busy_len = 0;
      done_at  = -1;
      for (int i = 0; i < 56; i++) begin
         @(negedge clk);
         if (i == 0) data_valid = 1'b0;
         if (busy1) busy_len++;
         if (busy1 && !tx1 && high_run == 0) low_run++;
         else if (busy1 && tx1) high_run++;
         if (done1 && done_at < 0) done_at = i;
      end
      check_val("slow_low_run",  low_run,  36);
      check_val("slow_high_run", high_run, 8);
      check_val("slow_busy_len", busy_len, 44);
      check_val("slow_done_at",  done_at,  44);

      send(8'h55, 1'b0, 1'b0);
      fork
         capture0(24, 1'b0);
         begin
            @(negedge clk);
            p_data = 8'hAA;
            repeat (11) @(negedge clk);
            data_valid = 1'b0;
         end
      join
      check_val("b2b_frame1", 32'(cap_tx[9:0]),    32'h2AA);
      check_val("b2b_frame2", 32'(cap_tx[19:10]),  32'h354);
      check_val("b2b_busy",   32'(cap_busy[23:0]), 32'h0FFFFF);
      check_val("b2b_done",   32'(cap_done[23:0]), 32'h100400);

      repeat (4) @(negedge clk);
      send(8'h3C, 1'b0, 1'b0);
      fork
         capture0(16, 1'b1);
         begin
            repeat (3) @(negedge clk);
            data_valid = 1'b1;
            p_data     = 8'hFF;
            par_en     = 1'b1;
            repeat (3) @(negedge clk);
            data_valid = 1'b0;
         end
      join
      check_val("midframe_line", 32'(cap_tx[9:0]),    32'h278);
      check_val("midframe_busy", 32'(cap_busy[15:0]), 32'h03FF);
      check_val("midframe_done", 32'(cap_done[15:0]), 32'h0400);

      repeat (4) @(negedge clk);
      send(8'hA5, 1'b0, 1'b0);
      @(negedge clk);
      data_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_bit("rst_async_tx0",   tx0,   1'b1);
      check_bit("rst_async_busy0", busy0, 1'b0);
      check_bit("rst_async_done0", done0, 1'b0);
      check_bit("rst_async_tx1",   tx1,   1'b1);
      repeat (2) @(negedge clk);
      rst        = 1'b0;
      p_data     = 8'hC3;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      data_valid = 1'b1;
      capture0(12, 1'b1);
      check_val("post_rst_line", 32'(cap_tx[10:0]),   32'h786);
      check_val("post_rst_busy", 32'(cap_busy[11:0]), 32'h3FF);
      check_val("post_rst_done", 32'(cap_done[11:0]), 32'h400);

      repeat (50) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
